spike_writeback: RTL and testbench
==================================

Name: spike_writeback

Overview:
- Downstream consumer of the neuron-matrix spike buffer.
- Each beat carries up to size_tile spiking-neuron addresses. The block compacts the valid lanes into a FIFO and drains them one per cycle into spike memory at per-timestep contiguous addresses.
- At each timestep boundary it reports the spike count. The controller uses this count as next layer's spike limit.

Parameters:
size_tile, 4, lanes per input beat
size_spike, 10, bits per spike address / count
num_timesteps, 10, timesteps per layer; time index wraps after num_timesteps-1
size_spike_max, 512, memory slots reserved per timestep
depth_fifo, 16, FIFO entries (power of 2, >= size_tile)
size_addr_spike_mem, 13, spike memory address width (>= clog2(num_timesteps*size_spike_max))

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low
in_valid  in  1  input beat valid (no backpressure)
in_lane_mask  in  size_tile  bit i = lane i carries a spike
in_spike  in  size_spike*size_tile  lane i address at [i*size_spike +: size_spike]
in_time_done  in  1  pulse: last beat of current timestep issued
mem_ready  in  1  spike memory accepts write this cycle
mem_we  out  1  write strobe
mem_addr  out  size_addr_spike_mem  cur_time*size_spike_max + wr_count
mem_data  out  size_spike  FIFO head
out_count_valid  out  1  one-cycle pulse, count report
out_spike_count  out  size_spike  spikes written this timestep
overflow  out  1  sticky: spike dropped
proto_err  out  1  sticky: in_valid or in_time_done while not RUN
busy  out  1  state != RUN or FIFO non-empty

Behaviour:
- Reset (reset=0, async) clears the following:
  - state=RUN; FIFO empty; wr_count=0; cur_time=0.
  - mem_we=0; out_count_valid=0; out_spike_count=0; overflow=0; proto_err=0.
  - Reset mid-operation discards FIFO contents without any further writes.
- Push (RUN, in_valid=1):
  - n = popcount(in_lane_mask).
  - Set lanes are enqueued in ascending lane order at the same edge.
  - Free space is evaluated before this cycle's pop.
  - If n > free, the whole beat is dropped and overflow is set. No partial beat is ever written.
  - n=0 is a no-op.
- Pop:
  - mem_we = FIFO non-empty AND state in {RUN, DRAIN}.
  - mem_data and mem_addr are combinational from the FIFO head and registers.
  - Pop and wr_count+1 happen only when mem_we AND mem_ready.
- Latency: a spike accepted at edge k appears on mem_we in cycle k+1 at the earliest.
- Simultaneous push and pop in the same cycle is legal. The FIFO count update is count + n - pop.
- Slot limit: if wr_count == size_spike_max at pop time, the entry is popped without mem_we (write suppressed), overflow is set, and wr_count holds.
- State machine:
  - RUN: accepts beats. On in_time_done=1 go to DRAIN. A beat in the same cycle as in_time_done belongs to the current timestep.
  - DRAIN: no pushes. When the FIFO is empty and no pop is pending, go to REPORT.
  - REPORT (1 cycle):
    - out_count_valid=1 and out_spike_count=wr_count. out_spike_count holds until the next report.
    - Then wr_count<=0 and cur_time<=cur_time+1, wrapping num_timesteps-1 -> 0. Go to RUN.
- in_valid or in_time_done seen in DRAIN or REPORT: ignored and proto_err set.
- A timestep with zero spikes gives DRAIN -> REPORT with count 0, so REPORT occurs 2 cycles after in_time_done.
- Address arithmetic is unsigned, with no truncation inside the declared widths.

Test Plan:
- Reset mid-stream: 3 entries queued, reset low for 1 cycle -> mem_we=0 immediately, busy=0, count, time and flags all 0.
- Mask 4'b1011 with lanes {5,6,7,8}, then in_time_done, mem_ready=1 -> writes (addr0,5), (addr1,6), (addr2,8); out_spike_count=3 pulse. Next timestep's first write goes to addr 512.
- mem_ready=0 while 4 full beats arrive (16 entries), then a 5th beat with mask 4'b0001 -> 5th beat dropped, overflow=1. After mem_ready=1, exactly 16 writes occur.
- in_time_done with empty FIFO -> out_count_valid 2 cycles later, out_spike_count=0. Repeat for 10 timesteps -> cur_time wraps, 11th timestep writes at addr 0.
- Simultaneous push and pop at FIFO count 15: push mask 4'b0001 -> accepted (free evaluated before pop, 1>=1), count stays 15, no overflow.
- in_valid during DRAIN -> beat ignored, proto_err=1, reported count unaffected.

Source files
------------

// File: rtl/spike_writeback_if.sv
// Spike-writeback bus: the input beat from the spike buffer and the spike-memory write port.
// The slave view belongs to spike_writeback; the master view belongs to its environment.
interface spike_writeback_if #(
    parameter int size_tile           = 4,
    parameter int size_spike          = 10,
    parameter int size_addr_spike_mem = 13
);
    logic                             in_valid;
    logic [size_tile-1:0]             in_lane_mask;
    logic [size_spike*size_tile-1:0]  in_spike;
    logic                             in_time_done;
    logic                             mem_ready;
    logic                             mem_we;
    logic [size_addr_spike_mem-1:0]   mem_addr;
    logic [size_spike-1:0]            mem_data;

    modport slave (
        input  in_valid, in_lane_mask, in_spike, in_time_done, mem_ready,
        output mem_we, mem_addr, mem_data
    );

    modport master (
        output in_valid, in_lane_mask, in_spike, in_time_done, mem_ready,
        input  mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/spike_writeback.sv
// Compacts multi-lane spike beats into a FIFO and drains them one per cycle into
// per-timestep contiguous spike-memory slots, reporting the spike count per timestep.
module spike_writeback #(
    parameter int size_tile           = 4,
    parameter int size_spike          = 10,
    parameter int num_timesteps       = 10,
    parameter int size_spike_max      = 512,
    parameter int depth_fifo          = 16,
    parameter int size_addr_spike_mem = 13
) (
    input  logic                   clk,
    input  logic                   reset,
    spike_writeback_if.slave       bus,
    output logic                   out_count_valid,
    output logic [size_spike-1:0]  out_spike_count,
    output logic                   overflow,
    output logic                   proto_err,
    output logic                   busy
);
    localparam int PTR_W  = $clog2(depth_fifo);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LANE_W = $clog2(size_tile + 1);
    localparam int TIME_W = (num_timesteps > 1) ? $clog2(num_timesteps) : 1;

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] REPORT = 2'd2;

    function automatic logic [TIME_W-1:0] next_time(input logic [TIME_W-1:0] t);
        if (t == TIME_W'(num_timesteps - 1))
            return '0;
        return t + TIME_W'(1);
    endfunction

    logic [1:0]            state;
    logic [size_spike-1:0] fifo_mem [depth_fifo];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic [size_spike-1:0] wr_count;
    logic [TIME_W-1:0]     cur_time;

    logic [LANE_W-1:0]     lane_offs [size_tile];
    logic [LANE_W-1:0]     beat_n;
    logic [CNT_W-1:0]      fifo_free;
    logic                  run;
    logic                  active;
    logic                  beat_fits;
    logic                  push;
    logic                  drop;
    logic                  head_valid;
    logic                  at_limit;
    logic                  pop;
    logic [CNT_W-1:0]      push_amt;
    logic [CNT_W-1:0]      pop_amt;

    // Each set lane lands at wr_ptr plus the number of set lanes below it.
    always_comb begin
        beat_n = '0;
        for (int i = 0; i < size_tile; i++) begin
            lane_offs[i] = beat_n;
            beat_n       = beat_n + LANE_W'(bus.in_lane_mask[i]);
        end
    end

    assign run        = (state == RUN);
    assign active     = (state == RUN) || (state == DRAIN);
    assign fifo_free  = CNT_W'(depth_fifo) - fifo_count;
    assign beat_fits  = (CNT_W'(beat_n) <= fifo_free);
    assign push       = run && bus.in_valid && (beat_n != '0) && beat_fits;
    assign drop       = run && bus.in_valid && !beat_fits;
    assign head_valid = (fifo_count != '0) && active;
    assign at_limit   = (wr_count == size_spike'(size_spike_max));
    // A slot-limited entry needs no memory cycle, so it is discarded without waiting on mem_ready.
    assign pop        = head_valid && (at_limit || bus.mem_ready);
    assign push_amt   = push ? CNT_W'(beat_n) : '0;
    assign pop_amt    = CNT_W'(pop);

    assign bus.mem_we   = head_valid && !at_limit;
    assign bus.mem_data = fifo_mem[rd_ptr];
    assign bus.mem_addr = size_addr_spike_mem'(cur_time) * size_addr_spike_mem'(size_spike_max)
                        + size_addr_spike_mem'(wr_count);
    assign busy         = !run || (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < size_tile; i++) begin
                if (bus.in_lane_mask[i])
                    fifo_mem[wr_ptr + PTR_W'(lane_offs[i])] <= bus.in_spike[i*size_spike +: size_spike];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= RUN;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            fifo_count      <= '0;
            wr_count        <= '0;
            cur_time        <= '0;
            out_count_valid <= 1'b0;
            out_spike_count <= '0;
            overflow        <= 1'b0;
            proto_err       <= 1'b0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(beat_n);
            fifo_count <= fifo_count + push_amt - pop_amt;
            if (pop && !at_limit)
                wr_count <= wr_count + size_spike'(1);
            if (drop || (head_valid && at_limit))
                overflow <= 1'b1;
            if (!run && (bus.in_valid || bus.in_time_done))
                proto_err <= 1'b1;

            out_count_valid <= 1'b0;
            case (state)
                RUN: begin
                    if (bus.in_time_done)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // Empty FIFO means no pop this edge, so wr_count is final.
                    if (fifo_count == '0) begin
                        state           <= REPORT;
                        out_count_valid <= 1'b1;
                        out_spike_count <= wr_count;
                    end
                end
                REPORT: begin
                    state    <= RUN;
                    wr_count <= '0;
                    cur_time <= next_time(cur_time);
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_spike_writeback.sv
// Directed bench for spike_writeback: a queue-based timestep model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_spike_writeback;
    localparam int size_tile           = 4;
    localparam int size_spike          = 10;
    localparam int num_timesteps       = 10;
    localparam int size_spike_max      = 512;
    localparam int depth_fifo          = 16;
    localparam int size_addr_spike_mem = 13;

    logic                  clk   = 1'b0;
    logic                  reset = 1'b0;
    logic                  out_count_valid;
    logic [size_spike-1:0] out_spike_count;
    logic                  overflow;
    logic                  proto_err;
    logic                  busy;

    spike_writeback_if #(
        .size_tile(size_tile), .size_spike(size_spike), .size_addr_spike_mem(size_addr_spike_mem)
    ) bus ();

    spike_writeback #(
        .size_tile(size_tile), .size_spike(size_spike), .num_timesteps(num_timesteps),
        .size_spike_max(size_spike_max), .depth_fifo(depth_fifo),
        .size_addr_spike_mem(size_addr_spike_mem)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .out_count_valid(out_count_valid),
        .out_spike_count(out_spike_count),
        .overflow(overflow),
        .proto_err(proto_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Timestep model: a queue of pending spikes plus per-timestep counters.
    int mq[$];
    int m_wr, m_time, m_cnt;
    bit m_drain, m_report, m_ovf, m_perr;

    task automatic m_reset();
        mq.delete();
        m_wr = 0; m_time = 0; m_cnt = 0;
        m_drain = 0; m_report = 0; m_ovf = 0; m_perr = 0;
    endtask

    task automatic m_compare();
        bit run_m;
        bit exp_we;
        run_m  = !m_drain && !m_report;
        exp_we = !m_report && (mq.size() > 0) && (m_wr != size_spike_max);
        chk("mem_we", int'(bus.mem_we), int'(exp_we));
        if (exp_we && bus.mem_we) begin
            chk("mem_addr", int'(bus.mem_addr), m_time * size_spike_max + m_wr);
            chk("mem_data", int'(bus.mem_data), mq[0]);
        end
        chk("count_valid", int'(out_count_valid), int'(m_report));
        chk("spike_count", int'(out_spike_count), m_cnt);
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("proto_err", int'(proto_err), int'(m_perr));
        chk("busy", int'(busy), int'(!run_m || (mq.size() != 0)));
    endtask

    task automatic m_step();
        int  free;
        int  pre;
        int  n;
        bit  run_m;
        pre   = mq.size();
        free  = depth_fifo - pre;
        run_m = !m_drain && !m_report;
        if (!m_report && pre > 0) begin
            if (m_wr == size_spike_max) begin
                void'(mq.pop_front());
                m_ovf = 1;
            end else if (bus.mem_ready) begin
                void'(mq.pop_front());
                m_wr++;
            end
        end
        if (run_m && bus.in_valid) begin
            n = $countones(bus.in_lane_mask);
            if (n > free)
                m_ovf = 1;
            else
                for (int i = 0; i < size_tile; i++)
                    if (bus.in_lane_mask[i])
                        mq.push_back(int'(bus.in_spike[i*size_spike +: size_spike]));
        end
        if (!run_m && (bus.in_valid || bus.in_time_done))
            m_perr = 1;
        if (m_report) begin
            m_report = 0;
            m_wr     = 0;
            m_time   = (m_time + 1) % num_timesteps;
        end else if (m_drain) begin
            if (pre == 0) begin
                m_drain  = 0;
                m_report = 1;
                m_cnt    = m_wr;
            end
        end else if (bus.in_time_done) begin
            m_drain = 1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) m_reset();
            m_compare();
            @(posedge clk);
            if (!reset) m_reset();
            else m_step();
        end
    end

    int wl_addr[$];
    int wl_data[$];
    always @(negedge clk) begin
        if (reset && bus.mem_we && bus.mem_ready) begin
            wl_addr.push_back(int'(bus.mem_addr));
            wl_data.push_back(int'(bus.mem_data));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] m, input int l0, input int l1,
                         input int l2, input int l3, input logic td);
        bus.in_valid     = v;
        bus.in_lane_mask = m;
        bus.in_spike     = {10'(l3), 10'(l2), 10'(l1), 10'(l0)};
        bus.in_time_done = td;
        cyc();
        bus.in_valid     = 1'b0;
        bus.in_lane_mask = '0;
        bus.in_spike     = '0;
        bus.in_time_done = 1'b0;
    endtask

    task automatic wait_report(input string name, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (out_count_valid) seen = 1;
            else cyc();
        end
        chk({name, "_report_seen"}, int'(seen), 1);
        cyc();
    endtask

    task automatic clear_log();
        wl_addr.delete();
        wl_data.delete();
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_lane_mask = '0;
        bus.in_spike     = '0;
        bus.in_time_done = 1'b0;
        bus.mem_ready    = 1'b1;
        cyc();
        cyc();
        chk("rst_mem_we", int'(bus.mem_we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(out_spike_count), 0);
        reset = 1'b1;
        cyc();

        // Timestep 0: mask 1011 compacts lanes 0,1,3.
        clear_log();
        drive(1, 4'b1011, 5, 6, 7, 8, 0);
        drive(0, 4'b0000, 0, 0, 0, 0, 1);
        wait_report("ts0", 20);
        chk("ts0_count", int'(out_spike_count), 3);
        chk("ts0_nwrites", wl_addr.size(), 3);
        if (wl_addr.size() == 3) begin
            chk("ts0_addr0", wl_addr[0], 0); chk("ts0_data0", wl_data[0], 5);
            chk("ts0_addr1", wl_addr[1], 1); chk("ts0_data1", wl_data[1], 6);
            chk("ts0_addr2", wl_addr[2], 2); chk("ts0_data2", wl_data[2], 8);
        end

        // Timestep 1 starts at slot base 512.
        clear_log();
        drive(1, 4'b0001, 9, 0, 0, 0, 0);
        drive(0, 4'b0000, 0, 0, 0, 0, 1);
        wait_report("ts1", 20);
        chk("ts1_nwrites", wl_addr.size(), 1);
        if (wl_addr.size() == 1) begin
            chk("ts1_addr", wl_addr[0], 512);
            chk("ts1_data", wl_data[0], 9);
        end

        // Timestep 2: push and pop together at 15 entries with one free slot.
        clear_log();
        bus.mem_ready = 1'b0;
        for (int b = 0; b < 4; b++)
            drive(1, 4'b1111, 100 + 4*b, 101 + 4*b, 102 + 4*b, 103 + 4*b, 0);
        bus.mem_ready = 1'b1;
        drive(0, 4'b0000, 0, 0, 0, 0, 0);
        drive(1, 4'b0001, 300, 0, 0, 0, 0);
        chk("pp_overflow", int'(overflow), 0);
        chk("pp_busy", int'(busy), 1);
        drive(0, 4'b0000, 0, 0, 0, 0, 1);
        wait_report("ts2", 40);
        chk("ts2_count", int'(out_spike_count), 17);
        chk("ts2_nwrites", wl_addr.size(), 17);
        if (wl_addr.size() == 17) begin
            chk("ts2_first_addr", wl_addr[0], 1024);
            chk("ts2_last_data", wl_data[16], 300);
        end

        // Timestep 3: 16 queued with memory stalled, the 5th beat must be dropped whole.
        clear_log();
        bus.mem_ready = 1'b0;
        for (int b = 0; b < 4; b++)
            drive(1, 4'b1111, 200 + 4*b, 201 + 4*b, 202 + 4*b, 203 + 4*b, 0);
        drive(1, 4'b0001, 500, 0, 0, 0, 0);
        chk("ovf_set", int'(overflow), 1);
        bus.mem_ready = 1'b1;
        drive(0, 4'b0000, 0, 0, 0, 0, 1);
        wait_report("ts3", 40);
        chk("ts3_count", int'(out_spike_count), 16);
        chk("ts3_nwrites", wl_addr.size(), 16);
        for (int i = 0; i < wl_addr.size() && i < 16; i++) begin
            chk("ts3_addr", wl_addr[i], 1536 + i);
            chk("ts3_data", wl_data[i], 200 + i);
        end

        // Reset with three entries pending: outputs and flags clear at once.
        bus.mem_ready = 1'b0;
        drive(1, 4'b0111, 1, 2, 3, 0, 0);
        chk("pre_rst_we", int'(bus.mem_we), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_we", int'(bus.mem_we), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_count", int'(out_spike_count), 0);
        chk("mid_rst_ovf", int'(overflow), 0);
        chk("mid_rst_perr", int'(proto_err), 0);
        cyc();
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        clear_log();

        // Ten empty timesteps: report exactly two cycles after in_time_done.
        for (int t = 0; t < num_timesteps; t++) begin
            drive(0, 4'b0000, 0, 0, 0, 0, 1);
            chk("empty_cv_early", int'(out_count_valid), 0);
            cyc();
            chk("empty_cv", int'(out_count_valid), 1);
            chk("empty_count", int'(out_spike_count), 0);
            cyc();
        end
        chk("discard_nwrites", wl_addr.size(), 0);

        // Eleventh timestep after reset: time index has wrapped to 0.
        drive(1, 4'b0001, 42, 0, 0, 0, 0);
        drive(0, 4'b0000, 0, 0, 0, 0, 1);
        wait_report("wrap", 20);
        chk("wrap_count", int'(out_spike_count), 1);
        chk("wrap_nwrites", wl_addr.size(), 1);
        if (wl_addr.size() == 1) begin
            chk("wrap_addr", wl_addr[0], 0);
            chk("wrap_data", wl_data[0], 42);
        end

        // Beat during DRAIN is ignored; beat with in_time_done counts.
        clear_log();
        drive(1, 4'b0001, 7, 0, 0, 0, 1);
        drive(1, 4'b1111, 50, 51, 52, 53, 0);
        chk("drain_perr", int'(proto_err), 1);
        wait_report("drain", 20);
        chk("drain_count", int'(out_spike_count), 1);
        chk("drain_nwrites", wl_addr.size(), 1);

        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
